// File: rtl/pe_scan_if.sv
// Handshake bundle for pe_scan: vector load side, beat output side and flush.
// The slave modport is the scanner; the master modport is whoever feeds and drains it.
interface pe_scan_if #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 5
);
  logic             in_valid;
  logic [WIDTH-1:0] in_vec;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;
  logic             out_none;
  logic [IDXW:0]    out_remain;

  modport slave (
    input  in_valid, in_vec, flush, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_none, out_remain
  );

  modport master (
    output in_valid, in_vec, flush, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_none, out_remain
  );
endinterface

// File: rtl/pe_scan.sv
// Priority-encoder scanner: loads a request bitmap and emits one beat per set bit,
// highest (MSB_FIRST=1) or lowest first, clearing each bit as its beat is accepted.
//
//   state  | meaning
//   IDLE   | waiting for a vector; in_ready high
//   SCAN   | hold register nonzero; presenting the current priority bit
//   ZERO   | accepted vector was all-zero; presenting the single "none" beat
module pe_scan #(
  parameter int WIDTH     = 32,
  parameter int IDXW      = 5,
  parameter int MSB_FIRST = 1
) (
  input  logic clk,
  input  logic reset,
  pe_scan_if.slave bus
);
  localparam int RW = IDXW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_ZERO = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic [RW-1:0]    remain, remain_nxt;
  logic [IDXW-1:0]  pri_idx;

  logic             in_ready;
  logic             out_valid;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;
  logic             out_none;
  logic [RW-1:0]    out_remain;

  // Later matches overwrite earlier ones, so scan direction picks the priority end.
  always_comb begin
    pri_idx = '0;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < WIDTH; i++)
        if (hold[i]) pri_idx = IDXW'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (hold[i]) pri_idx = IDXW'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      hold   <= '0;
      remain <= '0;
    end else begin
      state  <= state_nxt;
      hold   <= hold_nxt;
      remain <= remain_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold;
    remain_nxt = remain;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_idx    = '0;
    out_last   = 1'b0;
    out_none   = 1'b0;
    out_remain = '0;

    case (state)
      S_IDLE: begin
        // Gated by reset so in_ready reads 0 for the whole reset window.
        in_ready = !reset;
        if (bus.in_valid && in_ready) begin
          if (|bus.in_vec) begin
            hold_nxt   = bus.in_vec;
            remain_nxt = RW'($countones(bus.in_vec));
            state_nxt  = S_SCAN;
          end else begin
            state_nxt  = S_ZERO;
          end
        end
      end
      S_SCAN: begin
        out_valid  = 1'b1;
        out_idx    = pri_idx;
        out_remain = remain;
        out_last   = (remain == RW'(1));
        if (bus.out_ready) begin
          hold_nxt   = hold & ~(WIDTH'(1) << pri_idx);
          remain_nxt = remain - RW'(1);
          if (out_last) state_nxt = S_IDLE;
        end
      end
      S_ZERO: begin
        out_valid = 1'b1;
        out_none  = 1'b1;
        out_last  = 1'b1;
        if (bus.out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (bus.flush) begin
      state_nxt  = S_IDLE;
      hold_nxt   = '0;
      remain_nxt = '0;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_idx    = out_idx;
  assign bus.out_last   = out_last;
  assign bus.out_none   = out_none;
  assign bus.out_remain = out_remain;
endmodule

// File: doc/pe_scan.md
PE_SCAN -- requirements
Module: pe_scan

Interface
REQ-001 Parameter WIDTH, default 32: width of the request vector, at least 2.
REQ-002 Parameter IDXW, default 5: index width, equal to clog2(WIDTH).
REQ-003 Parameter MSB_FIRST, default 1: 1 = highest set bit has priority; 0 = lowest set bit has priority.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  in_vec is presented.
REQ-007 in_vec  input  WIDTH  request bitmap to scan.
REQ-008 in_ready  output  1  block accepts a new vector.
REQ-009 flush  input  1  synchronous abort of the current scan.
REQ-010 out_valid  output  1  out_idx, out_last and out_none are valid.
REQ-011 out_ready  input  1  consumer accepts the current beat.
REQ-012 out_idx  output  IDXW  index of the current priority bit.
REQ-013 out_last  output  1  current beat is the final beat for this vector.
REQ-014 out_none  output  1  accepted vector was all-zero.
REQ-015 out_remain  output  IDXW+1  set bits still held, including the current beat.

Function
REQ-016 The FSM shall have exactly three states: IDLE, SCAN and ZERO.
REQ-017 in_ready shall be 1 only in IDLE; a load occurs on any edge where in_valid and in_ready are both high.
REQ-018 On a load of a nonzero vector: register it into the hold register, set out_remain to its popcount, go to SCAN.
REQ-019 On a load of a zero vector: go to ZERO.
REQ-020 Latency: out_valid shall rise on the cycle after the load edge; there is no combinational path from in_vec to any output.
REQ-021 In SCAN: out_valid=1; out_idx = highest set bit of the hold register if MSB_FIRST=1, otherwise the lowest set bit; out_none=0.
REQ-022 In SCAN: out_last=1 exactly when out_remain==1.
REQ-023 On a handshake (out_valid & out_ready) in SCAN: clear bit out_idx in the hold register and decrement out_remain.
REQ-024 If that handshake beat has out_last=1, go to IDLE on the same edge.
REQ-025 If out_ready=0: out_idx, out_last and out_remain shall hold stable, one beat per handshake, no beat dropped or repeated.
REQ-026 In ZERO: out_valid=1, out_none=1, out_last=1, out_idx=0, out_remain=0.
REQ-027 In ZERO: on handshake go to IDLE.
REQ-028 In IDLE: out_valid=0; out_idx, out_last, out_none and out_remain shall be 0.
REQ-029 With continuous out_ready=1, a vector with k set bits shall produce k beats on k consecutive cycles.
REQ-030 After the last beat, IDLE lasts at least one cycle before the next load (no back-to-back overlap).
REQ-031 flush high on an edge shall force IDLE and clear the hold register, overriding any simultaneous handshake or load.
REQ-032 flush shall cause no beat in the following cycle.
REQ-033 in_vec changes while not in IDLE shall have no effect.

Reset
REQ-034 While reset is high: state=IDLE, hold register=0, all outputs 0 including in_ready, asynchronously.
REQ-035 in_ready shall rise on the first cycle after reset deasserts.
REQ-036 Reset asserted mid-scan shall abandon the scan with no further beats.

Verification
REQ-037 WIDTH=32, MSB_FIRST=1: load 0x10000000, out_ready=1 -> one beat idx=28, last=1, none=0, remain=1; then IDLE.
REQ-038 MSB_FIRST=1: load 0x0000000F, out_ready=1 -> idx 3,2,1,0 on consecutive cycles; remain 4,3,2,1; last only on idx 0.
REQ-039 MSB_FIRST=0 instance: load 0x000000FF -> idx 0..7 ascending; last on idx 7.
REQ-040 Load 0x00FFFF00 with out_ready=0 for 3 cycles -> idx=23, remain=16 held stable; next handshake gives idx 22.
REQ-041 Load 0x00000000 -> one beat none=1, last=1, idx=0, remain=0; then in_ready=1.
REQ-042 Load 0x0000FFFF, accept 2 beats (15,14), assert flush -> out_valid=0 next cycle, in_ready=1; a fresh load of 0x1 yields idx 0. Repeat with async reset instead of flush -> same result, and all outputs 0 immediately on reset.
